// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-state encoding and the arithmetic flag set.
//   state_t : IDLE (accepting operands), RUN (processing chunks), DONE (result held)
//   flags_t : carry, overflow, zero, negative
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

endpackage

// File: rtl/rca_n.sv
// Parametrised combinational ripple-carry slice built from full-adder cells.
// Ports:
//   op1, op2  : N-bit addends
//   carry_in  : carry into bit 0
//   sum       : N-bit sum
//   carry_out : carry out of bit N-1
module rca_n #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] op1,
  input  logic [N-1:0] op2,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);

  logic c;

  // Single ripple variable keeps the chain free of self-referencing vectors.
  always_comb begin
    c   = carry_in;
    sum = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum[i] = op1[i] ^ op2[i] ^ c;
      c      = (op1[i] & op2[i]) | (c & (op1[i] ^ op2[i]));
    end
    carry_out = c;
  end

endmodule

// File: rtl/add_sub_serial.sv
// Multi-cycle adder-subtractor: processes a WIDTH-bit add/sub CHUNK bits per
// clock through one narrow ripple-carry slice, with valid/ready on both sides.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (in_ready high only in IDLE)
//   op1, op2, sub         : operands; sub=1 computes op1 - op2
//   out_valid / out_ready : result handshake (out_valid high only in DONE)
//   result                : sum/difference mod 2^WIDTH
//   carry_out, overflow, zero, negative : flags, valid with out_valid
module add_sub_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("add_sub_serial: WIDTH must be >= 2");
  end
  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("add_sub_serial: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  state_t           state_q;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;       // already inverted when subtracting
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             zero_acc_q;
  logic             out_valid_q;
  flags_t           flags_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic             slice_carry;
  logic             sum_is_zero;
  logic             res_msb;

  assign a_chunk     = op1_q[cnt_q*CHUNK +: CHUNK];
  assign b_chunk     = op2_q[cnt_q*CHUNK +: CHUNK];
  assign sum_is_zero = (sum_chunk == '0);
  assign res_msb     = sum_chunk[CHUNK-1];

  rca_n #(
    .N(CHUNK)
  ) u_slice (
    .op1      (a_chunk),
    .op2      (b_chunk),
    .carry_in (carry_q),
    .sum      (sum_chunk),
    .carry_out(slice_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op1_q       <= '0;
      op2_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      zero_acc_q  <= 1'b0;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtract as op1 + ~op2 + 1: invert here, seed the +1 via the carry.
            op1_q      <= op1;
            op2_q      <= op2 ^ {WIDTH{sub}};
            carry_q    <= sub;
            cnt_q      <= '0;
            zero_acc_q <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          result_q[cnt_q*CHUNK +: CHUNK] <= sum_chunk;
          carry_q    <= slice_carry;
          zero_acc_q <= zero_acc_q & sum_is_zero;
          if (cnt_q == LAST) begin
            cnt_q            <= '0;
            flags_q.carry    <= slice_carry;
            flags_q.zero     <= zero_acc_q & sum_is_zero;
            flags_q.negative <= res_msb;
            // Like-signed operands whose result sign differs -> signed overflow.
            flags_q.overflow <= (op1_q[WIDTH-1] == op2_q[WIDTH-1]) &&
                                (res_msb != op1_q[WIDTH-1]);
            out_valid_q      <= 1'b1;
            state_q          <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;

endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: four instances (16/4, 16/1, 16/16, 32/8) driven
// by issue tasks that push expected responses into per-instance queues; a
// monitor pops and compares whenever an instance presents a result.
module tb_add_sub_serial;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;   // {carry, overflow, zero, negative}
    int          k;     // accept edge index
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        rst_a       [4];
  logic        in_valid_a  [4];
  logic        out_ready_a [4];
  logic        sub_a       [4];
  logic [31:0] op1_a       [4];
  logic [31:0] op2_a       [4];

  logic [3:0]       in_ready_v;
  logic [3:0]       out_valid_v;
  logic [3:0][31:0] result_v;
  logic [3:0][3:0]  flags_v;

  exp_t sbq  [4][$];
  bit   seen [4];
  bit   busy [4];

  function automatic int cfg_w(input int g);
    return (g == 3) ? 32 : 16;
  endfunction

  function automatic int cfg_c(input int g);
    case (g)
      0:       return 4;
      1:       return 1;
      2:       return 16;
      default: return 8;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned W = cfg_w(g);
    localparam int unsigned C = cfg_c(g);
    logic [W-1:0] res;
    logic         ir, ov, co, vf, zf, nf;

    add_sub_serial #(
      .WIDTH(W),
      .CHUNK(C)
    ) u_dut (
      .clk      (clk),
      .rst      (rst_a[g]),
      .in_valid (in_valid_a[g]),
      .in_ready (ir),
      .op1      (op1_a[g][W-1:0]),
      .op2      (op2_a[g][W-1:0]),
      .sub      (sub_a[g]),
      .out_valid(ov),
      .out_ready(out_ready_a[g]),
      .result   (res),
      .carry_out(co),
      .overflow (vf),
      .zero     (zf),
      .negative (nf)
    );

    assign in_ready_v[g]  = ir;
    assign out_valid_v[g] = ov;
    assign result_v[g]    = 32'(res);
    assign flags_v[g]     = {co, vf, zf, nf};
  end

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic s);
    exp_t    e;
    longint  full = longint'(1) << w;
    longint  half = full >> 1;
    longint  ua   = longint'({32'b0, a});
    longint  ub   = longint'({32'b0, b});
    longint  sa   = (ua >= half) ? ua - full : ua;
    longint  sb   = (ub >= half) ? ub - full : ub;
    longint  r, sr;
    logic    c, v;
    if (s) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      c  = (r >= full);
      sr = sa + sb;
    end
    r     = r & (full - 1);
    v     = (sr >= half) || (sr < -half);
    e.res = 32'(r);
    e.flg = {c, v, (r == 0), (r >= half)};
    e.k   = 0;
    return e;
  endfunction

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: latency and values checked when a result first appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (out_valid_v[i]) begin
          if (!seen[i]) begin
            seen[i] = 1'b1;
            if (sbq[i].size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_out[%0d]: got out_valid=1 expected no pending op", i);
            end else begin
              e = sbq[i][0];
              check($sformatf("latency[%0d]", i), 64'(cyc), 64'(e.k + cfg_w(i) / cfg_c(i)));
              check($sformatf("result[%0d]", i), 64'(result_v[i]), 64'(e.res));
              check($sformatf("flags[%0d]", i), 64'(flags_v[i]), 64'(e.flg));
            end
          end
          if (out_ready_a[i]) begin
            if (sbq[i].size() > 0) void'(sbq[i].pop_front());
            seen[i] = 1'b0;
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    bit   ok = 1'b0;
    op1_a[i]      = a;
    op2_a[i]      = b;
    sub_a[i]      = s;
    in_valid_a[i] = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (in_ready_v[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout[%0d]: got in_ready=0 for 500 cycles expected 1", i);
      in_valid_a[i] = 1'b0;
      return;
    end
    e   = model(cfg_w(i), a, b, s);
    e.k = cyc + 1;
    sbq[i].push_back(e);
    @(posedge clk);
    #1;
    // Scramble inputs after capture; the unit must ignore them.
    in_valid_a[i] = 1'b0;
    op1_a[i]      = $urandom;
    op2_a[i]      = $urandom;
    sub_a[i]      = ~s;
  endtask

  task automatic wait_done(input int i);
    for (int t = 0; t < 500; t++) begin
      if (sbq[i].size() == 0) break;
      @(posedge clk);
      #1;
    end
    check($sformatf("drain[%0d]", i), 64'(sbq[i].size()), 64'd0);
  endtask

  function automatic logic [31:0] pick(input logic [31:0] m);
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return m;
      2:       return m ^ (m >> 1);   // most negative
      3:       return m >> 1;         // most positive
      default: return 32'd1;
    endcase
  endfunction

  task automatic run_random(input int i);
    logic [31:0] m = (cfg_w(i) == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    logic [31:0] a, b;
    for (int n = 0; n < 1000; n++) begin
      a = ($urandom_range(0, 5) == 0) ? pick(m) : ($urandom & m);
      b = ($urandom_range(0, 5) == 0) ? pick(m) : ($urandom & m);
      issue(i, a, b, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_done(i);
    busy[i] = 1'b0;
  endtask

  task automatic drive_ready(input int i);
    while (busy[i]) begin
      @(posedge clk);
      #1;
      out_ready_a[i] = ($urandom_range(0, 3) != 0);
    end
    out_ready_a[i] = 1'b1;
  endtask

  initial begin
    exp_t e;
    bit   ok;
    for (int i = 0; i < 4; i++) begin
      rst_a[i]       = 1'b1;
      in_valid_a[i]  = 1'b0;
      out_ready_a[i] = 1'b1;
      sub_a[i]       = 1'b0;
      op1_a[i]       = 32'h0;
      op2_a[i]       = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_state[%0d]", i),
            64'({in_ready_v[i], out_valid_v[i], flags_v[i], result_v[i]}),
            64'({1'b1, 1'b0, 4'h0, 32'h0}));
      rst_a[i] = 1'b0;
    end

    // Basic add, subtract, wrap and overflow cases on the 16/4 instance.
    issue(0, 32'h1234, 32'h1111, 1'b0); wait_done(0);
    issue(0, 32'h0005, 32'h0005, 1'b1); wait_done(0);
    issue(0, 32'h0000, 32'h0001, 1'b1); wait_done(0);
    issue(0, 32'h7FFF, 32'h0001, 1'b0); wait_done(0);
    issue(0, 32'h8000, 32'h0001, 1'b1); wait_done(0);
    issue(0, 32'hFFFF, 32'h0001, 1'b0); wait_done(0);

    // Backpressure: result held, new operands ignored while DONE.
    out_ready_a[0] = 1'b0;
    e = model(16, 32'h1357, 32'h0246, 1'b0);
    issue(0, 32'h1357, 32'h0246, 1'b0);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid_v[0]) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_out_valid", 64'(ok), 64'd1);
    in_valid_a[0] = 1'b1;
    op1_a[0]      = 32'hAAAA;
    op2_a[0]      = 32'h5555;
    sub_a[0]      = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("bp_hold", 64'({in_ready_v[0], out_valid_v[0], flags_v[0], result_v[0]}),
            64'({1'b0, 1'b1, e.flg, e.res}));
    end
    in_valid_a[0] = 1'b0;
    @(posedge clk);
    #1;
    out_ready_a[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", 64'({out_valid_v[0], in_ready_v[0]}), 64'(2'b01));

    // Reset on the second RUN cycle abandons the operation.
    issue(0, 32'h1234, 32'h1111, 1'b0);
    @(posedge clk);
    #1;
    rst_a[0] = 1'b1;
    sbq[0].delete();
    @(posedge clk);
    #1;
    check("rst_mid_run", 64'({in_ready_v[0], out_valid_v[0], flags_v[0], result_v[0]}),
          64'({1'b1, 1'b0, 4'h0, 32'h0}));
    rst_a[0] = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    issue(0, 32'h00FF, 32'h0001, 1'b0); wait_done(0);

    // Randomised sweep on all four configurations with random backpressure.
    for (int i = 0; i < 4; i++) busy[i] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      automatic int j = i;
      fork
        run_random(j);
        drive_ready(j);
      join_none
    end
    wait fork;

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
